// File: rtl/secuenciador_sonido.sv
// secuenciador_sonido
//
// Sound sequencer for the game console. Plays a four-note melody when the
// game enters the welcome screen or the win/lose screen, and (optionally) a
// short FA click on every keypad press while otherwise silent.
//
// Parameters:
//   TICK_DIV  clk cycles per 1 ms tick
//   NOTE_MS   melody note duration, in ticks
//   GAP_MS    silence between melody notes, in ticks
//   CLICK_MS  keypad click duration, in ticks
//
// Ports:
//   clk             system clock, all logic on its rising edge
//   rst_n           asynchronous active-low reset
//   presente[2:0]   game state: OFF=0, WLCM=1, CH=2, GAME=3, WL=4, PA=5
//   W_or_L[1:0]     result code: 01 win, 10 lose, other none
//   keypad_pressed  level-high key-held indication
//   nota[2:0]       note code: 0 silence, 1 FA, 2 RE, 3 SOL, 4 DO, 5 SIB
//   busy            high while a melody (PLAY or GAP) is in progress
//
// Build option:
//   SONIDO_CLICK_EN  when defined, a keypad rising edge in IDLE plays a
//                    click; when undefined keypad_pressed is ignored.
//
// State  | meaning
// -------+-----------------------------------------------
// IDLE   | silent, waiting for a melody trigger or a key
// CLICK  | keypad click (FA) sounding
// PLAY   | melody note idx sounding
// GAP    | silence between melody notes

module secuenciador_sonido #(
    parameter int TICK_DIV = 27000,
    parameter int NOTE_MS  = 150,
    parameter int GAP_MS   = 20,
    parameter int CLICK_MS = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] presente,
    input  logic [1:0] W_or_L,
    input  logic       keypad_pressed,
    output logic [2:0] nota,
    output logic       busy
);

    localparam logic [2:0] P_OFF  = 3'd0;
    localparam logic [2:0] P_WLCM = 3'd1;
    localparam logic [2:0] P_WL   = 3'd4;

    localparam logic [2:0] N_SIL = 3'd0;
    localparam logic [2:0] N_FA  = 3'd1;
    localparam logic [2:0] N_RE  = 3'd2;
    localparam logic [2:0] N_SOL = 3'd3;
    localparam logic [2:0] N_DO  = 3'd4;
    localparam logic [2:0] N_SIB = 3'd5;

    localparam logic [1:0] M_WLCM = 2'd0;
    localparam logic [1:0] M_WIN  = 2'd1;
    localparam logic [1:0] M_LOSE = 2'd2;

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int T_MAX  = (NOTE_MS > GAP_MS) ?
                            ((NOTE_MS > CLICK_MS) ? NOTE_MS : CLICK_MS) :
                            ((GAP_MS > CLICK_MS) ? GAP_MS : CLICK_MS);
    localparam int TMR_W  = $clog2(T_MAX + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [TMR_W-1:0]  NOTE_END  = TMR_W'(NOTE_MS - 1);
    localparam logic [TMR_W-1:0]  GAP_END   = TMR_W'(GAP_MS - 1);
    localparam logic [TMR_W-1:0]  TMR_SAT   = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLICK = 2'd1,
        S_PLAY  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t            state;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [TMR_W-1:0]  timer;
    logic [TMR_W-1:0]  timer_inc;
    logic [1:0]        idx;
    logic [1:0]        mel_sel;
    logic [2:0]        pres_q;
    logic [2:0]        pres_prev;
    logic [1:0]        wl_q;
    logic              mel_trig;
    logic [1:0]        mel_new;
    logic              key_rise;

    function automatic logic [2:0] melody_note(input logic [1:0] sel, input logic [1:0] i);
        logic [2:0] n;
        n = N_SIL;
        case (sel)
            M_WLCM: case (i)
                2'd0:    n = N_DO;
                2'd1:    n = N_RE;
                2'd2:    n = N_FA;
                default: n = N_SOL;
            endcase
            M_WIN: case (i)
                2'd0:    n = N_SOL;
                2'd1:    n = N_SIB;
                2'd2:    n = N_DO;
                default: n = N_SIB;
            endcase
            default: case (i)
                2'd0:    n = N_SOL;
                2'd1:    n = N_FA;
                2'd2:    n = N_RE;
                default: n = N_DO;
            endcase
        endcase
        return n;
    endfunction

    // Free-running 1 ms tick; durations therefore carry up to one tick of
    // phase uncertainty on their first count.
    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // W_or_L is registered alongside presente so the melody choice sees the
    // result code that accompanied the state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pres_q    <= P_OFF;
            pres_prev <= P_OFF;
            wl_q      <= 2'b00;
        end else begin
            pres_q    <= presente;
            pres_prev <= pres_q;
            wl_q      <= W_or_L;
        end
    end

`ifdef SONIDO_CLICK_EN
    logic key_q;
    logic key_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q    <= 1'b0;
            key_prev <= 1'b0;
        end else begin
            key_q    <= keypad_pressed;
            key_prev <= key_q;
        end
    end

    assign key_rise = key_q & ~key_prev;
`else
    logic unused_keypad;
    assign unused_keypad = keypad_pressed;
    assign key_rise      = 1'b0;
`endif

    always_comb begin
        mel_trig = 1'b0;
        mel_new  = M_WLCM;
        if (pres_q != pres_prev) begin
            if (pres_q == P_WLCM) begin
                mel_trig = 1'b1;
                mel_new  = M_WLCM;
            end else if (pres_q == P_WL && wl_q == 2'b01) begin
                mel_trig = 1'b1;
                mel_new  = M_WIN;
            end else if (pres_q == P_WL && wl_q == 2'b10) begin
                mel_trig = 1'b1;
                mel_new  = M_LOSE;
            end
        end
    end

    assign timer_inc = (timer == TMR_SAT) ? timer : timer + TMR_W'(1);

    // OFF outranks every trigger; a melody trigger outranks a key edge and
    // restarts any melody already playing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            timer   <= '0;
            idx     <= 2'd0;
            mel_sel <= M_WLCM;
            nota    <= N_SIL;
            busy    <= 1'b0;
        end else if (pres_q == P_OFF) begin
            state <= S_IDLE;
            timer <= '0;
            idx   <= 2'd0;
            nota  <= N_SIL;
            busy  <= 1'b0;
        end else if (mel_trig) begin
            state   <= S_PLAY;
            timer   <= '0;
            idx     <= 2'd0;
            mel_sel <= mel_new;
            nota    <= melody_note(mel_new, 2'd0);
            busy    <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    timer <= '0;
                    nota  <= N_SIL;
                    busy  <= 1'b0;
                    if (key_rise) begin
                        state <= S_CLICK;
                        nota  <= N_FA;
                    end
                end
`ifdef SONIDO_CLICK_EN
                S_CLICK: begin
                    if (key_rise) begin
                        timer <= '0;
                    end else if (tick) begin
                        if (timer == TMR_W'(CLICK_MS - 1)) begin
                            state <= S_IDLE;
                            timer <= '0;
                            nota  <= N_SIL;
                        end else begin
                            timer <= timer_inc;
                        end
                    end
                end
`endif
                S_PLAY: begin
                    if (tick) begin
                        if (timer == NOTE_END) begin
                            state <= S_GAP;
                            timer <= '0;
                            nota  <= N_SIL;
                        end else begin
                            timer <= timer_inc;
                        end
                    end
                end
                S_GAP: begin
                    if (tick) begin
                        if (timer == GAP_END) begin
                            timer <= '0;
                            if (idx == 2'd3) begin
                                state <= S_IDLE;
                                idx   <= 2'd0;
                                busy  <= 1'b0;
                            end else begin
                                state <= S_PLAY;
                                idx   <= idx + 2'd1;
                                nota  <= melody_note(mel_sel, idx + 2'd1);
                            end
                        end else begin
                            timer <= timer_inc;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    timer <= '0;
                    nota  <= N_SIL;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_secuenciador_sonido.sv
// Directed bench for secuenciador_sonido with TICK_DIV=4, NOTE_MS=3,
// GAP_MS=2, CLICK_MS=5: a note lasts 12 cycles, a gap 8, a click 20, and the
// first interval after a trigger is shortened by up to one tick (9..12,
// 17..20). Click checks follow SONIDO_CLICK_EN.

module tb_secuenciador_sonido;

    logic       clk;
    logic       rst_n;
    logic [2:0] presente;
    logic [1:0] W_or_L;
    logic       keypad_pressed;
    logic [2:0] nota;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    secuenciador_sonido #(
        .TICK_DIV(4),
        .NOTE_MS (3),
        .GAP_MS  (2),
        .CLICK_MS(5)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .presente      (presente),
        .W_or_L        (W_or_L),
        .keypad_pressed(keypad_pressed),
        .nota          (nota),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  from_p;
        logic [2:0]  to_p;
        logic [1:0]  wl;
        bit          has_mel;
        logic [11:0] notes;   // {n3,n2,n1,n0}
        int          key_at;  // cycle into melody to press key, 0 = none
    } vec_t;

    vec_t vecs [8];

    task automatic check_int(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic check_range(input string nm, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d..%0d", nm, got, lo, hi);
        end
    endtask

    task automatic wait_val(input string nm, input logic b, input logic [2:0] n, input int maxc);
        int c;
        c = 0;
        while (!(busy === b && nota === n) && c < maxc) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (!(busy === b && nota === n)) begin
            failures++;
            $display("FAIL %s timeout busy=%0b nota=%0d exp busy=%0b nota=%0d", nm, busy, nota, b, n);
        end
    endtask

    task automatic check_quiet(input string nm, input int ncyc);
        int bad;
        bad = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || nota !== 3'd0) bad++;
        end
        check_int(nm, bad, 0);
    endtask

    task automatic capture_melody(input string nm, input logic [11:0] notes, input int key_at);
        logic [3:0] cur;
        logic [3:0] s;
        logic [3:0] ev;
        logic [3:0] vals [8];
        int         lens [8];
        int         nr;
        int         len;
        int         cyc;
        bit         done;
        wait_val($sformatf("%s start", nm), 1'b1, notes[2:0], 8);
        cur  = {busy, nota};
        len  = 1;
        nr   = 0;
        cyc  = 0;
        done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vals[i] = 4'd0;
            lens[i] = 0;
        end
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            s = {busy, nota};
            if (key_at != 0 && cyc == key_at) keypad_pressed = 1'b1;
            if (key_at != 0 && cyc == key_at + 2) keypad_pressed = 1'b0;
            if (s == cur) begin
                len++;
            end else begin
                if (nr < 8) begin
                    vals[nr] = cur;
                    lens[nr] = len;
                end
                nr++;
                cur = s;
                len = 1;
                if (s[3] == 1'b0) done = 1'b1;
            end
        end
        check_int($sformatf("%s runs", nm), nr, 8);
        for (int i = 0; i < 8; i++) begin
            if (i < nr) begin
                ev = (i % 2 == 0) ? {1'b1, notes[3*(i/2) +: 3]} : 4'b1000;
                check_int($sformatf("%s run%0d busy_nota", nm, i), int'(vals[i]), int'(ev));
                if (i == 0)
                    check_range($sformatf("%s run0 len", nm), lens[i], 9, 12);
                else
                    check_int($sformatf("%s run%0d len", nm, i), lens[i], (i % 2 == 0) ? 12 : 8);
            end
        end
        check_int($sformatf("%s end busy_nota", nm), int'(cur), 0);
    endtask

    int c;

    initial begin
        vecs[0] = '{3'd0, 3'd1, 2'b00, 1'b1, {3'd3, 3'd1, 3'd2, 3'd4}, 0};
        vecs[1] = '{3'd3, 3'd4, 2'b10, 1'b1, {3'd4, 3'd2, 3'd1, 3'd3}, 5};
        vecs[2] = '{3'd3, 3'd4, 2'b01, 1'b1, {3'd5, 3'd4, 3'd5, 3'd3}, 15};
        vecs[3] = '{3'd3, 3'd4, 2'b00, 1'b0, 12'd0, 0};
        vecs[4] = '{3'd3, 3'd4, 2'b11, 1'b0, 12'd0, 0};
        vecs[5] = '{3'd0, 3'd2, 2'b00, 1'b0, 12'd0, 0};
        vecs[6] = '{3'd2, 3'd1, 2'b00, 1'b1, {3'd3, 3'd1, 3'd2, 3'd4}, 0};
        vecs[7] = '{3'd3, 3'd5, 2'b01, 1'b0, 12'd0, 0};

        rst_n          = 1'b0;
        presente       = 3'd0;
        W_or_L         = 2'b00;
        keypad_pressed = 1'b0;
        repeat (2) @(negedge clk);
        check_int("reset nota", int'(nota), 0);
        check_int("reset busy", int'(busy), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            presente = 3'd0;
            repeat (3) @(negedge clk);
            presente = vecs[v].from_p;
            W_or_L   = vecs[v].wl;
            repeat (3) @(negedge clk);
            check_int($sformatf("vec%0d pre busy", v), int'(busy), 0);
            presente = vecs[v].to_p;
            if (vecs[v].has_mel)
                capture_melody($sformatf("vec%0d", v), vecs[v].notes, vecs[v].key_at);
            else
                check_quiet($sformatf("vec%0d quiet", v), 30);
        end

        // melody trigger and key edge on the same cycle: melody only
        presente = 3'd0;
        repeat (3) @(negedge clk);
        presente       = 3'd1;
        keypad_pressed = 1'b1;
        capture_melody("simul", {3'd3, 3'd1, 3'd2, 3'd4}, 0);
        keypad_pressed = 1'b0;

        // presente to OFF during second note
        presente = 3'd0;
        repeat (3) @(negedge clk);
        presente = 3'd1;
        wait_val("off note2", 1'b1, 3'd2, 40);
        repeat (3) @(negedge clk);
        presente = 3'd0;
        @(negedge clk);
        check_int("off hold busy", int'(busy), 1);
        check_int("off hold nota", int'(nota), 2);
        @(negedge clk);
        check_int("off busy", int'(busy), 0);
        check_int("off nota", int'(nota), 0);
        check_quiet("off stays quiet", 20);

        // retrigger during the first gap restarts at index 0
        presente = 3'd1;
        wait_val("retrig note0", 1'b1, 3'd4, 8);
        wait_val("retrig gap", 1'b1, 3'd0, 16);
        W_or_L   = 2'b01;
        presente = 3'd4;
        capture_melody("retrig", {3'd5, 3'd4, 3'd5, 3'd3}, 0);

        // asynchronous reset mid-melody
        presente = 3'd0;
        repeat (3) @(negedge clk);
        presente = 3'd1;
        wait_val("rst note2", 1'b1, 3'd2, 40);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_int("rst async nota", int'(nota), 0);
        check_int("rst async busy", int'(busy), 0);
        presente = 3'd3;
        @(negedge clk);
        rst_n = 1'b1;
        check_quiet("rst no resume", 30);

        presente = 3'd2;
        repeat (3) @(negedge clk);
`ifdef SONIDO_CLICK_EN
        // single click held: one 5-tick FA burst, no melody
        keypad_pressed = 1'b1;
        wait_val("click start", 1'b0, 3'd1, 4);
        c = 1;
        while (nota == 3'd1 && busy == 1'b0 && c < 40) begin
            @(negedge clk);
            c++;
        end
        check_range("click len", c - 1, 17, 20);
        check_int("click end nota", int'(nota), 0);
        check_int("click end busy", int'(busy), 0);
        keypad_pressed = 1'b0;
        repeat (3) @(negedge clk);

        // second edge about 3 ticks in restarts the 5-tick count
        keypad_pressed = 1'b1;
        wait_val("click2 start", 1'b0, 3'd1, 4);
        repeat (11) @(negedge clk);
        keypad_pressed = 1'b0;
        @(negedge clk);
        keypad_pressed = 1'b1;
        c = 0;
        while (c < 40) begin
            @(negedge clk);
            c++;
            if (nota != 3'd1) break;
        end
        check_range("click2 extend", c, 19, 22);
        check_int("click2 end nota", int'(nota), 0);
        keypad_pressed = 1'b0;
`else
        keypad_pressed = 1'b1;
        check_quiet("key ignored", 30);
        keypad_pressed = 1'b0;
`endif
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
